// File: rtl/drive_endpoint_tx_pkg.sv
// Shared definitions for the endpoint stimulus drivers: transaction encodings,
// LFSR taps and the transmit FSM state type.
package drive_endpoint_tx_pkg;

    localparam logic [2:0] TXN_NONE  = 3'b000;
    localparam logic [2:0] TXN_SETUP = 3'b100;
    localparam logic [2:0] TXN_OUT   = 3'b010;
    localparam logic [2:0] TXN_IN    = 3'b001;

    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } ep_tx_state_t;

    // One step of the right-shifting Galois LFSR.
    function automatic logic [15:0] lfsr_next(input logic [15:0] state);
        return state[0] ? ((state >> 1) ^ LFSR_TAPS) : (state >> 1);
    endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR with a seed parameter and enable; shared by the
// transmit, receive and transaction stimulus drivers.
module lfsr16
    import drive_endpoint_tx_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_en,
    output logic [15:0] o_state
);

    // An all-zero state would lock the LFSR, so a zero seed becomes 1.
    localparam logic [15:0] SEED_NZ = (SEED == 16'h0000) ? 16'h0001 : SEED;

    logic [15:0] r_state;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= SEED_NZ;
        end else if (i_en) begin
            r_state <= lfsr_next(r_state);
        end
    end

    assign o_state = r_state;

endmodule

// File: rtl/drive_endpoint_tx.sv
// Transmit endpoint stimulus generator: offers pseudo-random length packets with
// an incrementing byte pattern and drives a stall that only moves between transactions.
module drive_endpoint_tx
    import drive_endpoint_tx_pkg::*;
#(
    parameter int          MAX_PKT  = 8,
    parameter logic [15:0] SEED     = 16'hACE1,
    parameter bit          STALL_EN = 1'b0,
    localparam int         DATA_W   = 8 * MAX_PKT,
    localparam int         NBYTES_W = $clog2(MAX_PKT) + 1
) (
    input  logic                i_clk,
    input  logic                i_rst,
    output logic                o_etStall,
    input  logic                i_etReady,
    output logic                o_etValid,
    output logic [DATA_W-1:0]   o_etData,
    output logic [NBYTES_W-1:0] o_etData_nBytes,
    input  logic [2:0]          i_txnType
);

    logic [15:0]         w_lfsr;
    logic                w_unused_lfsr;
    logic                w_txn_active;
    logic [NBYTES_W-1:0] w_nbytes;
    logic [DATA_W-1:0]   w_data;

    ep_tx_state_t        r_state;
    logic [2:0]          r_gap;
    logic [7:0]          r_seq;
    logic                r_valid;
    logic [DATA_W-1:0]   r_data;
    logic [NBYTES_W-1:0] r_nbytes;
    logic [7:0]          r_stall_cnt;
    logic                r_stall;

    lfsr16 #(
        .SEED(SEED)
    ) u_lfsr (
        .i_clk  (i_clk),
        .i_rst_n(i_rst),
        .i_en   (1'b1),
        .o_state(w_lfsr)
    );

    assign w_unused_lfsr = ^w_lfsr;

    // Any set bit, including illegal multi-hot codes, counts as a transaction in flight.
    assign w_txn_active = |(i_txnType & (TXN_SETUP | TXN_OUT | TXN_IN));

    always_comb begin
        w_nbytes = w_lfsr[NBYTES_W-1:0];
        if (w_nbytes > NBYTES_W'(MAX_PKT)) begin
            w_nbytes = NBYTES_W'(MAX_PKT);
        end
        w_data = '0;
        for (int k = 0; k < MAX_PKT; k++) begin
            if (k < int'(w_nbytes)) begin
                w_data[8*k +: 8] = r_seq + 8'(k);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state  <= ST_IDLE;
            r_gap    <= '0;
            r_seq    <= '0;
            r_valid  <= 1'b0;
            r_data   <= '0;
            r_nbytes <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (r_gap == 3'd0) begin
                        r_data   <= w_data;
                        r_nbytes <= w_nbytes;
                        r_valid  <= 1'b1;
                        r_state  <= ST_OFFER;
                    end else begin
                        r_gap <= r_gap - 3'd1;
                    end
                end
                ST_OFFER: begin
                    // Payload and length stay frozen until the transactor takes them.
                    if (i_etReady) begin
                        r_seq   <= r_seq + 8'(r_nbytes);
                        r_gap   <= w_lfsr[2:0];
                        r_valid <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_stall_cnt <= '0;
            r_stall     <= 1'b0;
        end else begin
            r_stall_cnt <= r_stall_cnt + 8'd1;
            if (!w_txn_active) begin
                r_stall <= STALL_EN && (r_stall_cnt[7:4] == 4'hF);
            end
        end
    end

    assign o_etValid       = r_valid;
    assign o_etData        = r_data;
    assign o_etData_nBytes = r_nbytes;
    assign o_etStall       = r_stall;

endmodule

// File: tb/tb_drive_endpoint_tx.sv
// Self-checking bench for drive_endpoint_tx: directed phases with hand-computed
// packets plus a cycle-level reference of the packet, gap and stall behaviour.
module tb_drive_endpoint_tx;
    import drive_endpoint_tx_pkg::*;

    localparam int          MAX_PKT = 8;
    localparam int          DATA_W  = 8 * MAX_PKT;
    localparam int          NBW     = $clog2(MAX_PKT) + 1;
    localparam logic [15:0] SEED    = 16'hACE1;

    logic              i_clk = 1'b0;
    logic              i_rst;
    logic              i_etReady;
    logic [2:0]        i_txnType;
    logic              o_etStall;
    logic              o_etValid;
    logic [DATA_W-1:0] o_etData;
    logic [NBW-1:0]    o_etData_nBytes;

    always #5 i_clk = ~i_clk;

    drive_endpoint_tx #(
        .MAX_PKT (MAX_PKT),
        .SEED    (SEED),
        .STALL_EN(1'b1)
    ) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .o_etStall      (o_etStall),
        .i_etReady      (i_etReady),
        .o_etValid      (o_etValid),
        .o_etData       (o_etData),
        .o_etData_nBytes(o_etData_nBytes),
        .i_txnType      (i_txnType)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int n_acc    = 0;
    bit seen_zero = 1'b0;
    bit seen_max  = 1'b0;

    // Reference state: LFSR, stall counter, sequence byte, expected packet and gap.
    logic [15:0]       m_lfsr;
    logic [7:0]        m_cnt;
    logic [7:0]        m_seq;
    logic              m_stall;
    logic              m_pv;
    logic [DATA_W-1:0] m_data;
    logic [NBW-1:0]    m_nb;
    logic [2:0]        m_gap;
    int                m_idle;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    endfunction

    function automatic logic [DATA_W-1:0] pkt_bytes(input logic [7:0] seq, input logic [NBW-1:0] nb);
        logic [DATA_W-1:0] d;
        d = '0;
        for (int k = 0; k < MAX_PKT; k++) begin
            if (k < int'(nb)) d[8*k +: 8] = seq + 8'(k);
        end
        return d;
    endfunction

    task automatic model_reset();
        m_lfsr  = SEED;
        m_cnt   = 8'd0;
        m_seq   = 8'd0;
        m_stall = 1'b0;
        m_pv    = 1'b0;
        m_data  = '0;
        m_nb    = '0;
        m_gap   = 3'd0;
        m_idle  = 0;
    endtask

    // One clock: advance the reference with the inputs seen at the edge, then check.
    task automatic step();
        logic        acc;
        logic        rst_pre;
        logic [15:0] l_pre;
        logic [7:0]  c_pre;
        logic [2:0]  t_pre;
        logic        e_valid;
        acc     = m_pv && i_etReady;
        rst_pre = i_rst;
        l_pre   = m_lfsr;
        c_pre   = m_cnt;
        t_pre   = i_txnType;
        if (o_etValid && i_etReady) n_acc++;
        @(posedge i_clk);
        #1;
        if (!rst_pre) return;
        m_lfsr = lfsr_step(l_pre);
        m_cnt  = c_pre + 8'd1;
        if (t_pre == TXN_NONE) m_stall = (c_pre[7:4] == 4'hF);
        check_eq("stall", 64'(o_etStall), 64'(m_stall));
        if (acc) begin
            check_eq("valid_drop", 64'(o_etValid), 64'd0);
            m_seq  = m_seq + 8'(m_nb);
            m_gap  = l_pre[2:0];
            m_idle = 0;
            m_pv   = 1'b0;
        end else if (m_pv) begin
            check_eq("hold_valid", 64'(o_etValid), 64'd1);
            check_eq("hold_data", o_etData, m_data);
            check_eq("hold_nbytes", 64'(o_etData_nBytes), 64'(m_nb));
        end else begin
            m_idle++;
            e_valid = (m_idle == int'(m_gap) + 1);
            check_eq("valid_timing", 64'(o_etValid), 64'(e_valid));
            if (e_valid) begin
                m_nb   = (l_pre[3:0] > 4'd8) ? 4'd8 : l_pre[3:0];
                m_data = pkt_bytes(m_seq, m_nb);
                check_eq("pkt_nbytes", 64'(o_etData_nBytes), 64'(m_nb));
                check_eq("pkt_data", o_etData, m_data);
                m_pv = 1'b1;
            end
        end
        if (o_etValid && o_etData_nBytes == 4'd0) begin
            seen_zero = 1'b1;
            check_eq("zero_len_data", o_etData, 64'd0);
        end
        if (o_etValid && o_etData_nBytes == 4'd8) seen_max = 1'b1;
    endtask

    task automatic check_outputs_clear(input string tag);
        check_eq({tag, "_valid"}, 64'(o_etValid), 64'd0);
        check_eq({tag, "_stall"}, 64'(o_etStall), 64'd0);
        check_eq({tag, "_data"}, o_etData, 64'd0);
        check_eq({tag, "_nbytes"}, 64'(o_etData_nBytes), 64'd0);
    endtask

    initial begin
        int stall_hi;
        i_rst     = 1'b0;
        i_etReady = 1'b0;
        i_txnType = TXN_NONE;
        model_reset();
        #2;
        check_outputs_clear("reset_async");
        repeat (5) begin
            step();
            check_outputs_clear("reset_hold");
        end

        // SEED low nibble is 1, so the first packet is one byte of value 0.
        i_rst = 1'b1;
        step();
        check_eq("first_valid", 64'(o_etValid), 64'd1);
        check_eq("first_nbytes", 64'(o_etData_nBytes), 64'd1);
        check_eq("first_data", o_etData, 64'd0);

        repeat (50) step();

        i_etReady = 1'b1;
        n_acc = 0;
        for (int c = 0; c < 4000 && n_acc < 200; c++) step();
        check_eq("accept_count", 64'(n_acc), 64'd200);

        for (int c = 0; c < 300; c++) begin
            i_etReady = 1'($urandom_range(0, 1));
            step();
        end

        // An OUT transaction straddling the stall window suppresses it entirely.
        for (int c = 0; c < 300 && m_cnt != 8'd235; c++) step();
        i_txnType = TXN_OUT;
        repeat (25) begin
            step();
            check_eq("stall_hold_out", 64'(o_etStall), 64'd0);
        end
        i_txnType = TXN_NONE;

        // A multi-hot code entered mid-window holds the stall high past the window.
        for (int c = 0; c < 300 && m_cnt != 8'd245; c++) step();
        check_eq("stall_in_window", 64'(o_etStall), 64'd1);
        i_txnType = 3'b111;
        repeat (30) begin
            step();
            check_eq("stall_hold_multi", 64'(o_etStall), 64'd1);
        end
        i_txnType = TXN_NONE;
        step();
        check_eq("stall_release", 64'(o_etStall), 64'd0);

        stall_hi = 0;
        repeat (256) begin
            step();
            if (o_etStall) stall_hi++;
        end
        check_eq("stall_window_len", 64'(stall_hi), 64'd16);

        // Reset while a packet is offered, then replay the first packets from SEED.
        i_etReady = 1'b0;
        for (int c = 0; c < 20 && !o_etValid; c++) step();
        check_eq("pre_reset_valid", 64'(o_etValid), 64'd1);
        i_rst = 1'b0;
        #1;
        check_outputs_clear("mid_reset");
        model_reset();
        i_etReady = 1'b1;
        step();
        i_rst = 1'b1;
        step();
        check_eq("replay_first_nbytes", 64'(o_etData_nBytes), 64'd1);
        check_eq("replay_first_data", o_etData, 64'd0);
        step();
        check_eq("replay_gap_valid", 64'(o_etValid), 64'd0);
        step();
        check_eq("replay_second_nbytes", 64'(o_etData_nBytes), 64'd8);
        check_eq("replay_second_data", o_etData, 64'h0807060504030201);

        check_eq("seen_zero_len", 64'(seen_zero), 64'd1);
        check_eq("seen_max_len", 64'(seen_max), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/drive_endpoint_tx.md
Name: drive_endpoint_tx

Overview:
- Synthesizable stimulus generator for one transmit endpoint of the USB full-speed transactor, used in host and device roles.
- Offers packets of pseudo-random length over a valid/ready handshake, with a predictable incrementing byte pattern so a receive-side checker can verify the payload.
- Drives a pseudo-random endpoint stall that changes only between transactions.

Parameters:
- MAX_PKT, 8, maximum packet payload in bytes (power of 2, ≥ 2).
- SEED, 16'hACE1, non-zero LFSR seed. A value of 0 is replaced by 16'h0001.
- STALL_EN, 0, when 1, periodic stall windows are generated; when 0, o_etStall is held at 0.
- Derived, not overridable: DATA_W = 8*MAX_PKT; NBYTES_W = clog2(MAX_PKT)+1.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset, asynchronous, active-low.
- o_etStall  out  1  endpoint stall request.
- i_etReady  in  1  transactor accepts the packet this cycle.
- o_etValid  out  1  packet offered.
- o_etData  out  DATA_W  payload; byte k occupies bits [8k+7:8k].
- o_etData_nBytes  out  NBYTES_W  payload length, range 0..MAX_PKT.
- i_txnType  in  3  one-hot {SETUP, OUT, IN}; 0 means no transaction in flight.

Behaviour:
- All state is cleared asynchronously when i_rst=0. Reset values:
  - o_etValid=0, o_etStall=0, o_etData=0, o_etData_nBytes=0.
  - LFSR=SEED, sequence byte seq=0, state IDLE, gap counter=0, stall counter=0.
- LFSR:
  - 16-bit Galois, taps 16'hB400, shift right, XOR the taps when the LSB is 1.
  - Advances every cycle out of reset.
- State machine IDLE/OFFER:
  - IDLE: o_etValid=0. The gap counter decrements each cycle. When it is 0 in IDLE, the packet is loaded and the state moves to OFFER on the next edge.
  - Load: nBytes = LFSR[NBYTES_W-1:0], clamped to MAX_PKT if larger. Byte k = seq+k (mod 256) for k<nBytes; bytes k≥nBytes are 0.
  - OFFER: o_etValid=1. o_etData and o_etData_nBytes are held stable until accepted. Valid never deasserts without acceptance.
  - Accept = o_etValid && i_etReady. On accept: seq += nBytes (mod 256), gap counter = LFSR[2:0], return to IDLE. Minimum one idle cycle between packets.
- A zero-length packet is legal: nBytes=0, all data 0, seq unchanged.
- i_etReady while o_etValid=0 is ignored.
- Stall (STALL_EN=1):
  - A free-running 8-bit stall counter increments every cycle.
  - Stall target: 1 when counter[7:4]==4'hF (16 of every 256 cycles), else 0.
  - o_etStall takes the target only on cycles with i_txnType==0. Otherwise it holds its value, so the stall never changes mid-transaction.
- Stall does not gate the packet generator. The transactor decides whether to use the offered packet.
- i_txnType with more than one bit set is treated as non-zero (hold).
- All outputs are registered. Accept-to-next-valid latency is at least 2 cycles (IDLE gap+1).

Decomposition:
- Shared package holds:
  - the USB txn-type one-hot encodings (SETUP=3'b100, OUT=3'b010, IN=3'b001);
  - the LFSR tap constant 16'hB400.
- One natural sub-module, lfsr16: Galois LFSR with seed parameter, enable, and asynchronous active-low reset. It is reused by the receive-side and transaction drivers.
- The rest (FSM, packet build, stall) stays flat.

Test Plan:
- Reset:
  - hold i_rst=0 for 5 cycles → all outputs 0;
  - release → o_etValid rises within 1+LFSR[2:0]-derived gap ≤ 9 cycles.
- Hold stability: i_etReady=0 for 50 cycles after o_etValid=1 → o_etValid, o_etData, o_etData_nBytes unchanged all 50 cycles.
- Sequence continuity:
  - i_etReady=1 constantly for 200 accepts → each packet's byte0 equals previous byte0+previous nBytes (mod 256);
  - byte k = byte0+k; bytes ≥ nBytes are 0; nBytes ≤ 8.
- Zero-length and max packets: run until nBytes=0 and nBytes=8 both occur → length 0 gives o_etData=0 and seq unchanged; length 8 has all bytes populated.
- Stall gating (STALL_EN=1):
  - i_txnType=3'b010 held across cycle 240..260 → o_etStall does not change during the hold;
  - with i_txnType=0, o_etStall=1 exactly for counter 240..255 (one-cycle register delay).
- Mid-packet reset: assert i_rst=0 while o_etValid=1 → outputs clear immediately without a clock; after release, first packet byte0=0 and the LFSR sequence repeats from SEED.
